// File: rtl/multiply_adder_arbiter.sv
// ---------------------------------------------------------------------------
// multiply_adder_arbiter
//
// Shares one external pipelined multiply-adder (o = a*b + c, fixed LATENCY,
// never stalls, not reset) between NREQ requesters. One op is issued per
// cycle by round-robin. A shadow tag pipe records which requester issued
// each op, so results are routed back to that requester in issue order.
// An enable/drain FSM stops new grants and waits for in-flight ops to
// return before going idle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   en           1 = grants allowed, 0 = drain and stop
//   req_valid    per-requester request valid
//   req_ready    per-requester grant (one-hot or zero), combinational
//   req_a/b      per-requester operands, requester i at [i*BITS +: BITS]
//   req_c        per-requester addend, requester i at [i*2*BITS +: 2*BITS]
//   resp_valid   one-cycle result pulse to the issuing requester
//   resp_o       shared result bus, holds its last value between pulses
//   mul_a/b/c    operands to the multiply-adder (zero when nothing granted)
//   mul_o        result from the multiply-adder
//   state        0 IDLE, 1 RUN, 2 DRAIN
//   inflight     ops issued but not yet responded
//   op_count     total accepted ops, wraps at 2^32
// ---------------------------------------------------------------------------
module multiply_adder_arbiter #(
  parameter int BITS    = 64,
  parameter int NREQ    = 4,
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BITS-1:0]     req_a,
  input  logic [NREQ*BITS-1:0]     req_b,
  input  logic [NREQ*2*BITS-1:0]   req_c,
  output logic [NREQ-1:0]          resp_valid,
  output logic [2*BITS-1:0]        resp_o,
  output logic [BITS-1:0]          mul_a,
  output logic [BITS-1:0]          mul_b,
  output logic [2*BITS-1:0]        mul_c,
  input  logic [2*BITS-1:0]        mul_o,
  output logic [1:0]               state,
  output logic [2:0]               inflight,
  output logic [31:0]              op_count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Tag pipe covers the multiply-adder latency plus the result register.
  localparam int DEPTH = LATENCY + 1;
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                   state_reg, state_next;
  logic [IDX_W-1:0]             rr_ptr_reg, rr_ptr_next;
  logic [DEPTH-1:0]             tag_valid_reg;
  logic [DEPTH-1:0][IDX_W-1:0]  tag_idx_reg;
  logic [2*BITS-1:0]            resp_o_reg;
  logic [2:0]                   inflight_reg, inflight_next;
  logic [31:0]                  op_count_reg;

  logic                         grant_en;
  logic                         grant_any;
  logic [IDX_W-1:0]             grant_idx;
  logic [IDX_W:0]               cand_sum;
  logic [NREQ-1:0]              grant;
  logic                         resp_any;

  logic [NREQ-1:0][BITS-1:0]    a_masked;
  logic [NREQ-1:0][BITS-1:0]    b_masked;
  logic [NREQ-1:0][2*BITS-1:0]  c_masked;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: scan upward from the pointer, wrapping mod NREQ.
  // -------------------------------------------------------------------------
  assign grant_en = en && ((state_reg == IDLE) || (state_reg == RUN));

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (cand_sum >= NREQ_W) begin
        cand_sum = cand_sum - NREQ_W;
      end
      if (grant_en && !grant_any && req_valid[cand_sum[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // One-hot grant and per-requester operand masking; the masked operands
  // are OR-reduced so no wide indexed mux is needed.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign grant[gi]    = grant_any && (grant_idx == IDX_W'(gi));
      assign a_masked[gi] = req_a[gi*BITS +: BITS] & {BITS{grant[gi]}};
      assign b_masked[gi] = req_b[gi*BITS +: BITS] & {BITS{grant[gi]}};
      assign c_masked[gi] = req_c[gi*2*BITS +: 2*BITS] & {(2*BITS){grant[gi]}};
    end
  endgenerate

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    mul_c = '0;
    for (int k = 0; k < NREQ; k++) begin
      mul_a = mul_a | a_masked[k];
      mul_b = mul_b | b_masked[k];
      mul_c = mul_c | c_masked[k];
    end
  end

  assign req_ready = grant;

  // -------------------------------------------------------------------------
  // Response routing. Stage LATENCY-1 lines up with mul_o being valid; the
  // last stage lines up with the registered result in resp_o.
  // -------------------------------------------------------------------------
  assign resp_any = tag_valid_reg[DEPTH-1];

  always_comb begin
    resp_valid = '0;
    if (resp_any) begin
      resp_valid[tag_idx_reg[DEPTH-1]] = 1'b1;
    end
  end

  assign inflight_next = inflight_reg + {2'b00, grant_any} - {2'b00, resp_any};

  // -------------------------------------------------------------------------
  // Enable/drain FSM. DRAIN only leaves once nothing is outstanding, so a
  // late en=1 cannot restart issue while old results are still returning.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if ((inflight_reg == 3'd0) && !resp_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The multiply-adder itself is not reset; clearing the tag pipe is what
  // guarantees no stale result is ever reported after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      tag_valid_reg <= '0;
      tag_idx_reg   <= '0;
      resp_o_reg    <= '0;
      inflight_reg  <= '0;
      op_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      tag_valid_reg <= {tag_valid_reg[DEPTH-2:0], grant_any};
      tag_idx_reg   <= {tag_idx_reg[DEPTH-2:0], grant_idx};
      if (tag_valid_reg[LATENCY-1]) begin
        resp_o_reg <= mul_o;
      end
      inflight_reg  <= inflight_next;
      if (grant_any) begin
        op_count_reg <= op_count_reg + 32'd1;
      end
    end
  end

  assign state    = state_reg;
  assign resp_o   = resp_o_reg;
  assign inflight = inflight_reg;
  assign op_count = op_count_reg;

endmodule

// File: tb/tb_multiply_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multiply_adder_arbiter
//
// Testbench for multiply_adder_arbiter. Provides a behavioural model of the
// external multiply-adder, a queue-based reference model of issue order and
// response timing checked every cycle, and directed scenario tasks.
// ---------------------------------------------------------------------------
module tb_multiply_adder_arbiter;

  localparam int BITS       = 64;
  localparam int NREQ       = 4;
  localparam int LATENCY    = 4;
  localparam int RESP_DELAY = LATENCY + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*BITS-1:0]   req_a = '0;
  logic [NREQ*BITS-1:0]   req_b = '0;
  logic [NREQ*2*BITS-1:0] req_c = '0;
  logic [NREQ-1:0]        resp_valid;
  logic [2*BITS-1:0]      resp_o;
  logic [BITS-1:0]        mul_a;
  logic [BITS-1:0]        mul_b;
  logic [2*BITS-1:0]      mul_c;
  logic [2*BITS-1:0]      mul_o;
  logic [1:0]             state;
  logic [2:0]             inflight;
  logic [31:0]            op_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiply_adder_arbiter #(.BITS(BITS), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .resp_valid(resp_valid), .resp_o(resp_o),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_o(mul_o),
    .state(state), .inflight(inflight), .op_count(op_count)
  );

  // External multiply-adder: LATENCY-stage pipe, unreset, truncating.
  logic [2*BITS-1:0] mac_pipe [LATENCY];
  always @(posedge clk) begin
    mac_pipe[0] <= {{BITS{1'b0}}, mul_a} * {{BITS{1'b0}}, mul_b} + mul_c;
    for (int s = 1; s < LATENCY; s++) mac_pipe[s] <= mac_pipe[s-1];
  end
  assign mul_o = mac_pipe[LATENCY-1];

  // ---------------------------------------------------------------------
  // Reference model: ops are queued with the cycle their result is due.
  // ---------------------------------------------------------------------
  typedef struct {
    int                due;
    int                idx;
    logic [2*BITS-1:0] val;
  } op_t;

  op_t               m_q[$];
  int                m_ptr = 0;
  int                m_state = 0;   // 0 idle, 1 run, 2 drain
  int                m_infl = 0;
  int                e_idx = 0;
  logic [31:0]       m_count = '0;
  logic [2*BITS-1:0] m_last_o = '0;
  logic [NREQ-1:0]   e_ready;
  logic [NREQ-1:0]   e_resp;
  logic [BITS-1:0]   e_a, e_b;
  logic [2*BITS-1:0] e_c, e_val;
  op_t               e_op;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_ptr = 0;
      m_state = 0;
      m_count = '0;
      m_last_o = '0;
    end else begin
      m_infl = m_q.size();
      e_idx = -1;
      if (en && (m_state == 0 || m_state == 1)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (e_idx < 0 && req_valid[(m_ptr + k) % NREQ]) e_idx = (m_ptr + k) % NREQ;
        end
      end
      e_ready = '0; e_a = '0; e_b = '0; e_c = '0;
      if (e_idx >= 0) begin
        e_ready[e_idx] = 1'b1;
        e_a = req_a[e_idx*BITS +: BITS];
        e_b = req_b[e_idx*BITS +: BITS];
        e_c = req_c[e_idx*2*BITS +: 2*BITS];
      end
      n_checks++;
      if (req_ready !== e_ready) begin
        n_errors++;
        $display("FAIL model_grant cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready);
      end
      n_checks++;
      if ({mul_a, mul_b, mul_c} !== {e_a, e_b, e_c}) begin
        n_errors++;
        $display("FAIL model_mul_operands cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                 cyc, mul_a, mul_b, mul_c, e_a, e_b, e_c);
      end
      n_checks++;
      if (state !== 2'(m_state)) begin
        n_errors++;
        $display("FAIL model_state cyc=%0d got=%0d exp=%0d", cyc, state, m_state);
      end
      n_checks++;
      if (inflight !== 3'(m_infl)) begin
        n_errors++;
        $display("FAIL model_inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl);
      end
      n_checks++;
      if (op_count !== m_count) begin
        n_errors++;
        $display("FAIL model_op_count cyc=%0d got=%0d exp=%0d", cyc, op_count, m_count);
      end
      e_resp = '0;
      if (m_q.size() > 0 && m_q[0].due <= cyc) begin
        e_resp[m_q[0].idx] = 1'b1;
        m_last_o = m_q[0].val;
        void'(m_q.pop_front());
      end
      n_checks++;
      if (resp_valid !== e_resp) begin
        n_errors++;
        $display("FAIL model_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, e_resp);
      end
      n_checks++;
      if (resp_o !== m_last_o) begin
        n_errors++;
        $display("FAIL model_resp_o cyc=%0d got=%h exp=%h", cyc, resp_o, m_last_o);
      end
      if (e_idx >= 0) begin
        e_val = {{BITS{1'b0}}, e_a} * {{BITS{1'b0}}, e_b} + e_c;
        e_op.due = cyc + RESP_DELAY;
        e_op.idx = e_idx;
        e_op.val = e_val;
        m_q.push_back(e_op);
        m_ptr = (e_idx + 1) % NREQ;
        m_count = m_count + 32'd1;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = 2;
        default: if (m_infl == 0) m_state = 0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------
  function automatic logic [BITS-1:0] rnd64();
    if ($urandom_range(0, 7) == 0) return '1;
    return {$urandom, $urandom};
  endfunction

  task automatic set_ops(input int i, input logic [BITS-1:0] a,
                         input logic [BITS-1:0] b, input logic [2*BITS-1:0] c);
    req_a[i*BITS +: BITS]     = a;
    req_b[i*BITS +: BITS]     = b;
    req_c[i*2*BITS +: 2*BITS] = c;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; en = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++;
    if (resp_valid !== '0) begin n_errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_checks++;
    if (resp_o !== '0) begin n_errors++; $display("FAIL reset_resp_o got=%h exp=0", resp_o); end
    n_checks++;
    if (inflight !== 3'd0) begin n_errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    n_checks++;
    if (op_count !== 32'd0) begin n_errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    @(posedge clk); #1 rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_op();
    en = 1'b1;
    set_ops(0, 64'd3, 64'd5, 128'd7);
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);   // cycle N+4
    n_checks++;
    if (resp_valid !== 4'b0000) begin n_errors++; $display("FAIL single_early got=%b exp=0000", resp_valid); end
    @(negedge clk);              // cycle N+5
    n_checks++;
    if (resp_valid !== 4'b0001) begin n_errors++; $display("FAIL single_resp_valid got=%b exp=0001", resp_valid); end
    n_checks++;
    if (resp_o !== 128'd22) begin n_errors++; $display("FAIL single_resp_o got=%0d exp=22", resp_o); end
    @(negedge clk);              // cycle N+6
    n_checks++;
    if (resp_valid !== 4'b0000) begin n_errors++; $display("FAIL single_late got=%b exp=0000", resp_valid); end
    $display("test_single_op: 3*5+7 -> %0d", resp_o);
  endtask

  task automatic test_max_values();
    logic [2*BITS-1:0] exp_o;
    // (2^64-1)^2 + (2^128-1) = 2^129 - 2^65, truncated to 128 bits: 2^128 - 2^65
    exp_o = {64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
    @(posedge clk); #1;
    set_ops(1, '1, '1, '1);
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL max_grant got=%b exp=0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (resp_valid !== 4'b0010) begin n_errors++; $display("FAIL max_resp_valid got=%b exp=0010", resp_valid); end
    n_checks++;
    if (resp_o !== exp_o) begin n_errors++; $display("FAIL max_resp_o got=%h exp=%h", resp_o, exp_o); end
    $display("test_max_values: resp_o=%h", resp_o);
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_g, exp_r;
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, rnd64(), rnd64(), {rnd64(), rnd64()});
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_g = '0; exp_g[k % NREQ] = 1'b1;
      n_checks++;
      if (req_ready !== exp_g) begin
        n_errors++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, req_ready, exp_g);
      end
      exp_r = '0;
      if (k >= RESP_DELAY) exp_r[(k - RESP_DELAY) % NREQ] = 1'b1;
      n_checks++;
      if (resp_valid !== exp_r) begin
        n_errors++; $display("FAIL contention_resp k=%0d got=%b exp=%b", k, resp_valid, exp_r);
      end
      $display("contention k=%0d grant=%b resp=%b", k, req_ready, resp_valid);
      @(posedge clk); #1;
      set_ops(k % NREQ, rnd64(), rnd64(), {rnd64(), rnd64()});
    end
    req_valid = '0;
  endtask

  task automatic test_pointer_fairness();
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL fair_grant2 got=%b exp=0100", req_ready); end
    @(posedge clk); #1 req_valid = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL fair_grant3_first got=%b exp=1000", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL fair_grant1_next got=%b exp=0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    $display("test_pointer_fairness done");
  endtask

  task automatic test_drain();
    logic [NREQ-1:0] exp_g;
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) set_ops(i, rnd64(), rnd64(), {rnd64(), rnd64()});
    req_valid = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      exp_g = '0; exp_g[j] = 1'b1;
      n_checks++;
      if (req_ready !== exp_g) begin
        n_errors++; $display("FAIL drain_issue j=%0d got=%b exp=%b", j, req_ready, exp_g);
      end
      @(posedge clk); #1 req_valid[j] = 1'b0;
    end
    en = 1'b0;
    req_valid = 4'b1000;          // must not be granted while draining
    for (int t = 3; t <= 12; t++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0) begin n_errors++; $display("FAIL drain_no_grant t=%0d got=%b", t, req_ready); end
      if (t == 4 || t == 7) begin
        n_checks++;
        if (state !== 2'd2) begin n_errors++; $display("FAIL drain_state t=%0d got=%0d exp=2", t, state); end
      end
      if (t == 7) begin
        n_checks++;
        if (resp_valid !== 4'b0100) begin n_errors++; $display("FAIL drain_last_resp got=%b exp=0100", resp_valid); end
      end
      if (t == 8) begin
        n_checks++;
        if (inflight !== 3'd0) begin n_errors++; $display("FAIL drain_inflight got=%0d exp=0", inflight); end
      end
      if (t == 9) begin
        n_checks++;
        if (state !== 2'd0) begin n_errors++; $display("FAIL drain_idle got=%0d exp=0", state); end
      end
    end
    @(posedge clk); #1 req_valid = '0;
    $display("test_drain done state=%0d inflight=%0d", state, inflight);
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    en = 1'b1;
    set_ops(0, rnd64(), rnd64(), {rnd64(), rnd64()});
    set_ops(1, rnd64(), rnd64(), {rnd64(), rnd64()});
    req_valid = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_grant0 got=%b exp=0001", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL midrst_grant1 got=%b exp=0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== '0) begin n_errors++; $display("FAIL midrst_in_reset got=%b exp=0", resp_valid); end
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== '0) begin n_errors++; $display("FAIL midrst_ghost t=%0d got=%b", t, resp_valid); end
      n_checks++;
      if (op_count !== 32'd0) begin n_errors++; $display("FAIL midrst_op_count t=%0d got=%0d exp=0", t, op_count); end
    end
    @(posedge clk); #1 req_valid = '1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_ptr got=%b exp=0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] acc;
    for (int i = 0; i < NREQ; i++) set_ops(i, rnd64(), rnd64(), {rnd64(), rnd64()});
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      $display("random n=%0d valid=%b grant=%b resp=%b state=%0d", n, req_valid, req_ready, resp_valid, state);
      @(posedge clk); #1;
      en = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_ops(i, rnd64(), rnd64(), {rnd64(), rnd64()});
          req_valid[i] = 1'b1;
        end
      end
    end
    en = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_quiesce();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(state == 2'd0 && inflight == 3'd0) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (state !== 2'd0 || inflight !== 3'd0) begin
      n_errors++; $display("FAIL quiesce_timeout state=%0d inflight=%0d exp=0/0", state, inflight);
    end
    $display("test_quiesce: idle after %0d cycles", waited);
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_max_values();
    test_contention();
    test_pointer_fairness();
    test_drain();
    test_reset_midflight();
    test_random();
    test_quiesce();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
